// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order circular queue of loads and stores feeding the
// cache data port. Loads to ordinary memory go out as soon as they reach the
// head. Stores and I/O loads (addr[17:16] == 2'b11) wait for a ROB commit.
// A misprediction clear drops every uncommitted entry.
module load_store_buffer #(
  parameter int LSB_WIDTH = 3,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clkIn,
  input  logic                 resetIn,
  input  logic                 clearIn,
  input  logic                 issueValid,
  output logic                 issueReady,
  input  logic                 issueIsLoad,
  input  logic [1:0]           issueAccessType,
  input  logic                 issueSigned,
  input  logic [ROB_WIDTH-1:0] issueRobId,
  input  logic [31:0]          issueAddr,
  input  logic [31:0]          issueData,
  input  logic                 commitValid,
  input  logic [ROB_WIDTH-1:0] commitRobId,
  output logic [1:0]           accessType,
  output logic                 readWriteOut,
  output logic [31:0]          dataAddrOut,
  output logic [31:0]          dataOut,
  input  logic                 dataInValid,
  input  logic [31:0]          dataIn,
  input  logic                 dataWriteSuc,
  output logic                 resultValid,
  output logic [ROB_WIDTH-1:0] resultRobId,
  output logic [31:0]          resultValue
);

  localparam int Depth = 1 << LSB_WIDTH;
  localparam logic [LSB_WIDTH:0] FullCount = (LSB_WIDTH + 1)'(Depth);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, WAIT_STORE} state_t;

  typedef struct packed {
    logic                 isLoad;
    logic [1:0]           accType;
    logic                 isSigned;
    logic [ROB_WIDTH-1:0] robId;
    logic [31:0]          addr;
    logic [31:0]          data;
  } payload_t;

  state_t                 state;
  state_t                 nextState;
  logic [Depth-1:0]       entryValid;
  logic [Depth-1:0]       entryCommitted;
  payload_t               payload [Depth];
  logic [LSB_WIDTH-1:0]   head;
  logic [LSB_WIDTH-1:0]   tail;
  logic [LSB_WIDTH:0]     count;

  payload_t               headEntry;
  logic                   headEligible;
  logic                   reqActive;
  logic                   doEnq;
  logic                   enqCommitted;
  logic [Depth-1:0]       commitHit;
  logic [Depth-1:0]       committedEff;
  logic [LSB_WIDTH:0]     committedCnt;
  logic                   issueReq;
  logic                   popHead;
  logic                   captureResult;
  logic                   flushLoad;
  logic                   headLeaves;
  logic [31:0]            extendedLoad;

  assign issueReady   = (count != FullCount);
  assign doEnq        = issueValid && issueReady && !clearIn;
  assign enqCommitted = commitValid && (issueRobId == commitRobId);
  assign headEntry    = payload[head];
  assign reqActive    = (accessType != 2'b00);

  // Ordinary loads may go out speculatively; stores and I/O loads need a commit.
  assign headEligible = entryValid[head] &&
                        (entryCommitted[head] ||
                         (headEntry.isLoad && headEntry.addr[17:16] != 2'b11));

  // Commit matches against live entries, and the committed set as seen by a clear.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    commitHit    = '0;
    committedCnt = '0;
    for (int i = 0; i < Depth; i++) begin
      commitHit[i] = commitValid && entryValid[i] && (payload[i].robId == commitRobId);
    end
    committedEff = entryCommitted | commitHit;
    for (int i = 0; i < Depth; i++) begin
      committedCnt = committedCnt + (LSB_WIDTH + 1)'(entryValid[i] & committedEff[i]);
    end
  end

  // Cache-port FSM: state register.
  always_ff @(posedge clkIn or negedge resetIn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!resetIn) state <= IDLE;
    else          state <= nextState;
  end

  // Cache-port FSM: next state and per-cycle control strobes. The request
  // cycle itself is spent in IDLE with accessType nonzero, so the wait states
  // never see a live request.
  always_comb begin
    nextState     = state;
    issueReq      = 1'b0;
    popHead       = 1'b0;
    captureResult = 1'b0;
    flushLoad     = 1'b0;
    unique case (state)
      IDLE: begin
        if (reqActive) begin
          if (readWriteOut && clearIn) flushLoad = 1'b1;
          else nextState = readWriteOut ? WAIT_LOAD : WAIT_STORE;
        end else if (headEligible && !clearIn) begin
          issueReq = 1'b1;
        end
      end
      WAIT_LOAD: begin
        if (clearIn) begin
          flushLoad = 1'b1;
          nextState = IDLE;
        end else if (dataInValid) begin
          captureResult = 1'b1;
          popHead       = 1'b1;
          nextState     = IDLE;
        end
      end
      WAIT_STORE: begin
        if (dataWriteSuc) begin
          popHead   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // An abandoned load leaves the queue only if it survives the clear itself
  // (a committed I/O load); an uncommitted head is removed by the invalidation.
  assign headLeaves = flushLoad ? (entryValid[head] && committedEff[head]) : popHead;

  // Queue bookkeeping: pointers, count, valid and committed flags.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      entryValid     <= '0;
      entryCommitted <= '0;
    end else if (clearIn) begin
      head           <= head + LSB_WIDTH'(headLeaves);
      tail           <= head + committedCnt[LSB_WIDTH-1:0];
      count          <= committedCnt - (LSB_WIDTH + 1)'(headLeaves);
      entryCommitted <= committedEff;
      for (int i = 0; i < Depth; i++) begin
        entryValid[i] <= entryValid[i] && committedEff[i] &&
                         !(headLeaves && (LSB_WIDTH'(i) == head));
      end
    end else begin
      entryCommitted <= committedEff;
      if (popHead) begin
        entryValid[head] <= 1'b0;
        head             <= head + 1'b1;
      end
      if (doEnq) begin
        entryValid[tail]     <= 1'b1;
        entryCommitted[tail] <= enqCommitted;
        tail                 <= tail + 1'b1;
      end
      count <= count + (LSB_WIDTH + 1)'(doEnq) - (LSB_WIDTH + 1)'(popHead);
    end
  end

  // Entry payload storage, written at the tail on enqueue.
  always_ff @(posedge clkIn) begin
    // NOTE: payload needs no reset; the valid bits alone decide what is live.
    if (doEnq) begin
      payload[tail] <= '{isLoad:   issueIsLoad,
                         accType:  issueAccessType,
                         isSigned: issueSigned,
                         robId:    issueRobId,
                         addr:     issueAddr,
                         data:     issueData};
    end
  end

  // Load result extension from the zero-extended cache data.
  always_comb begin
    unique case (headEntry.accType)
      2'b01:   extendedLoad = {{24{headEntry.isSigned & dataIn[7]}},  dataIn[7:0]};
      2'b10:   extendedLoad = {{16{headEntry.isSigned & dataIn[15]}}, dataIn[15:0]};
      default: extendedLoad = dataIn;
    endcase
  end

  // Registered cache request: driven for exactly one cycle per head entry.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      accessType   <= 2'b00;
      readWriteOut <= 1'b1;
      dataAddrOut  <= '0;
      dataOut      <= '0;
    end else if (issueReq) begin
      accessType   <= headEntry.accType;
      readWriteOut <= headEntry.isLoad;
      dataAddrOut  <= headEntry.addr;
      dataOut      <= headEntry.data;
    end else begin
      accessType   <= 2'b00;
    end
  end

  // Registered load-result broadcast, valid for one cycle per completed load.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      resultValid <= 1'b0;
      resultRobId <= '0;
      resultValue <= '0;
    end else begin
      resultValid <= captureResult;
      if (captureResult) begin
        resultRobId <= headEntry.robId;
        resultValue <= extendedLoad;
      end
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
// tb_load_store_buffer: directed scenarios plus a randomized run checked
// against a queue-of-entries reference model and a reactive cache model.
module tb_load_store_buffer;

  logic        clkIn = 1'b0;
  logic        resetIn = 1'b0;
  logic        clearIn = 1'b0;
  logic        issueValid = 1'b0;
  logic        issueReady;
  logic        issueIsLoad = 1'b0;
  logic [1:0]  issueAccessType = 2'b00;
  logic        issueSigned = 1'b0;
  logic [3:0]  issueRobId = '0;
  logic [31:0] issueAddr = '0;
  logic [31:0] issueData = '0;
  logic        commitValid = 1'b0;
  logic [3:0]  commitRobId = '0;
  logic [1:0]  accessType;
  logic        readWriteOut;
  logic [31:0] dataAddrOut;
  logic [31:0] dataOut;
  logic        dataInValid = 1'b0;
  logic [31:0] dataIn = '0;
  logic        dataWriteSuc = 1'b0;
  logic        resultValid;
  logic [3:0]  resultRobId;
  logic [31:0] resultValue;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    bit         isLoad;
    bit [1:0]   at;
    bit         sgn;
    bit [3:0]   rob;
    bit [31:0]  addr;
    bit [31:0]  data;
    bit         committed;
  } entry_t;

  load_store_buffer #(.LSB_WIDTH(3), .ROB_WIDTH(4)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn),
    .issueValid(issueValid), .issueReady(issueReady), .issueIsLoad(issueIsLoad),
    .issueAccessType(issueAccessType), .issueSigned(issueSigned),
    .issueRobId(issueRobId), .issueAddr(issueAddr), .issueData(issueData),
    .commitValid(commitValid), .commitRobId(commitRobId),
    .accessType(accessType), .readWriteOut(readWriteOut),
    .dataAddrOut(dataAddrOut), .dataOut(dataOut),
    .dataInValid(dataInValid), .dataIn(dataIn), .dataWriteSuc(dataWriteSuc),
    .resultValid(resultValid), .resultRobId(resultRobId), .resultValue(resultValue)
  );

  always #5 clkIn = ~clkIn;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected load value from the extension rules, by plain arithmetic.
  function automatic logic [31:0] extendRef(input bit [1:0] at, input bit sgn, input logic [31:0] raw);
    longint v;
    if (at == 2'b01) begin
      v = raw & 32'hFF;
      if (sgn && v >= 128) v = v - 256;
    end else if (at == 2'b10) begin
      v = raw & 32'hFFFF;
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      v = raw;
    end
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic clearInputs();
    clearIn = 0; issueValid = 0; issueIsLoad = 0; issueAccessType = 0; issueSigned = 0;
    issueRobId = 0; issueAddr = 0; issueData = 0; commitValid = 0; commitRobId = 0;
    dataInValid = 0; dataIn = 0; dataWriteSuc = 0;
  endtask

  task automatic doReset();
    clearInputs();
    resetIn = 0;
    tick();
    tick();
    resetIn = 1;
  endtask

  task automatic enqueue(input bit ld, input logic [1:0] at, input bit sgn,
                         input logic [3:0] rob, input logic [31:0] addr, input logic [31:0] data);
    issueValid = 1; issueIsLoad = ld; issueAccessType = at; issueSigned = sgn;
    issueRobId = rob; issueAddr = addr; issueData = data;
    tick();
    issueValid = 0;
  endtask

  task automatic commitId(input logic [3:0] rob);
    commitValid = 1; commitRobId = rob;
    tick();
    commitValid = 0;
  endtask

  task automatic waitReq(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i <= budget && !seen; i++) begin
      if (accessType !== 2'b00) seen = 1;
      else if (i < budget) tick();
    end
  endtask

  task automatic quiet(input int n, output bit sawReq, output bit sawRes);
    sawReq = 0; sawRes = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (accessType !== 2'b00) sawReq = 1;
      if (resultValid !== 1'b0) sawRes = 1;
    end
  endtask

  // Called in the request cycle; returns at the sample point of the result cycle.
  task automatic respondLoad(input logic [31:0] raw);
    tick();
    dataInValid = 1; dataIn = raw;
    tick();
    dataInValid = 0;
  endtask

  task automatic test_reset();
    clearInputs();
    resetIn = 0;
    tick();
    tick();
    checks++;
    if (accessType !== 2'b00 || readWriteOut !== 1'b1 || dataAddrOut !== 32'h0 || dataOut !== 32'h0) begin
      fails++;
      $display("FAIL reset_request: got at=%b rw=%b addr=%h data=%h want 00/1/0/0", accessType, readWriteOut, dataAddrOut, dataOut);
    end
    checks++;
    if (resultValid !== 1'b0 || resultRobId !== 4'h0 || resultValue !== 32'h0 || issueReady !== 1'b1) begin
      fails++;
      $display("FAIL reset_result: got rv=%b rob=%h val=%h ready=%b want 0/0/0/1", resultValid, resultRobId, resultValue, issueReady);
    end
    resetIn = 1;
    tick();
  endtask

  task automatic test_load_byte();
    logic [31:0] want;
    bit sawReq, sawRes;
    for (int s = 1; s >= 0; s--) begin
      want = (s == 1) ? 32'hFFFFFFF0 : 32'h000000F0;
      enqueue(1, 2'b01, bit'(s), 4'd3, 32'h100, 32'h0);
      tick();
      checks++;
      if (accessType !== 2'b01 || readWriteOut !== 1'b1 || dataAddrOut !== 32'h100) begin
        fails++;
        $display("FAIL lb_request_s%0d: got at=%b rw=%b addr=%h want 01/1/00000100", s, accessType, readWriteOut, dataAddrOut);
      end
      tick();
      checks++;
      if (accessType !== 2'b00) begin
        fails++;
        $display("FAIL lb_request_one_cycle_s%0d: got at=%b want 00", s, accessType);
      end
      dataInValid = 1; dataIn = 32'h000000F0;
      tick();
      dataInValid = 0;
      checks++;
      if (resultValid !== 1'b1 || resultRobId !== 4'd3 || resultValue !== want) begin
        fails++;
        $display("FAIL lb_result_s%0d: got rv=%b rob=%h val=%h want 1/3/%h", s, resultValid, resultRobId, resultValue, want);
      end
      quiet(1, sawReq, sawRes);
      checks++;
      if (sawRes) begin
        fails++;
        $display("FAIL lb_result_one_cycle_s%0d: got rv=1 want 0", s);
      end
    end
  endtask

  task automatic test_store();
    bit seen, sawReq, sawRes;
    doReset();
    enqueue(0, 2'b11, 0, 4'd5, 32'h200, 32'hDEADBEEF);
    quiet(5, sawReq, sawRes);
    checks++;
    if (sawReq) begin fails++; $display("FAIL st_before_commit: got request want none"); end
    commitId(4'd5);
    checks++;
    if (accessType !== 2'b00) begin fails++; $display("FAIL st_commit_edge: got at=%b want 00", accessType); end
    tick();
    checks++;
    if (accessType !== 2'b11 || readWriteOut !== 1'b0 || dataAddrOut !== 32'h200 || dataOut !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL st_request: got at=%b rw=%b addr=%h data=%h want 11/0/00000200/deadbeef", accessType, readWriteOut, dataAddrOut, dataOut);
    end
    enqueue(1, 2'b11, 0, 4'd6, 32'h300, 32'h0);
    checks++;
    if (accessType !== 2'b00) begin fails++; $display("FAIL st_request_one_cycle: got at=%b want 00", accessType); end
    quiet(4, sawReq, sawRes);
    checks++;
    if (sawReq) begin fails++; $display("FAIL st_hold_until_suc: got request want none"); end
    dataWriteSuc = 1;
    tick();
    dataWriteSuc = 0;
    waitReq(4, seen);
    checks++;
    if (!seen || dataAddrOut !== 32'h300 || readWriteOut !== 1'b1) begin
      fails++;
      $display("FAIL st_pop_then_load: got seen=%b addr=%h rw=%b want 1/00000300/1", seen, dataAddrOut, readWriteOut);
    end
    respondLoad(32'h87654321);
    checks++;
    if (resultValid !== 1'b1 || resultRobId !== 4'd6 || resultValue !== 32'h87654321) begin
      fails++;
      $display("FAIL st_next_load_result: got rv=%b rob=%h val=%h want 1/6/87654321", resultValid, resultRobId, resultValue);
    end
  endtask

  task automatic test_full_wrap();
    bit seen, sawReq, sawRes;
    logic [31:0] raw;
    doReset();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        checks++;
        if (issueReady !== 1'b1) begin fails++; $display("FAIL full_ready_at7: got %b want 1", issueReady); end
      end
      enqueue(1, 2'b11, 0, 4'(i), 32'h1000 + 32'(4 * i), 32'h0);
    end
    checks++;
    if (issueReady !== 1'b0) begin fails++; $display("FAIL full_not_ready: got %b want 0", issueReady); end
    enqueue(1, 2'b11, 0, 4'd8, 32'h1100, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        waitReq(4, seen);
        checks++;
        if (!seen || dataAddrOut !== 32'h1000 + 32'(4 * i)) begin
          fails++;
          $display("FAIL drain_req_%0d: got seen=%b addr=%h want 1/%h", i, seen, dataAddrOut, 32'h1000 + 32'(4 * i));
        end
      end
      raw = 32'h11111111 * 32'(i + 1);
      respondLoad(raw);
      checks++;
      if (resultValid !== 1'b1 || resultRobId !== 4'(i) || resultValue !== raw) begin
        fails++;
        $display("FAIL drain_res_%0d: got rv=%b rob=%h val=%h want 1/%h/%h", i, resultValid, resultRobId, resultValue, 4'(i), raw);
      end
    end
    checks++;
    if (issueReady !== 1'b1) begin fails++; $display("FAIL drained_ready: got %b want 1", issueReady); end
    quiet(5, sawReq, sawRes);
    checks++;
    if (sawReq || sawRes) begin fails++; $display("FAIL dropped_when_full: got req=%b res=%b want 0/0", sawReq, sawRes); end
    enqueue(1, 2'b10, 0, 4'd9, 32'h2000, 32'h0);
    waitReq(4, seen);
    checks++;
    if (!seen || accessType !== 2'b10 || dataAddrOut !== 32'h2000) begin
      fails++;
      $display("FAIL wrap_req: got seen=%b at=%b addr=%h want 1/10/00002000", seen, accessType, dataAddrOut);
    end
    respondLoad(32'h0000ABCD);
    checks++;
    if (resultValid !== 1'b1 || resultRobId !== 4'd9 || resultValue !== 32'h0000ABCD) begin
      fails++;
      $display("FAIL wrap_res: got rv=%b rob=%h val=%h want 1/9/0000abcd", resultValid, resultRobId, resultValue);
    end
  endtask

  task automatic test_io_load();
    bit seen, sawReq, sawRes;
    doReset();
    enqueue(1, 2'b10, 1, 4'd7, 32'h30000, 32'h0);
    quiet(6, sawReq, sawRes);
    checks++;
    if (sawReq) begin fails++; $display("FAIL io_before_commit: got request want none"); end
    commitId(4'd7);
    waitReq(4, seen);
    checks++;
    if (!seen || dataAddrOut !== 32'h30000 || readWriteOut !== 1'b1) begin
      fails++;
      $display("FAIL io_req: got seen=%b addr=%h rw=%b want 1/00030000/1", seen, dataAddrOut, readWriteOut);
    end
    respondLoad(32'h00008001);
    checks++;
    if (resultValid !== 1'b1 || resultRobId !== 4'd7 || resultValue !== 32'hFFFF8001) begin
      fails++;
      $display("FAIL io_res: got rv=%b rob=%h val=%h want 1/7/ffff8001", resultValid, resultRobId, resultValue);
    end
    enqueue(1, 2'b11, 0, 4'd8, 32'h30004, 32'h0);
    quiet(3, sawReq, sawRes);
    clearIn = 1;
    tick();
    clearIn = 0;
    quiet(6, sawReq, sawRes);
    checks++;
    if (sawReq || sawRes) begin fails++; $display("FAIL io_cleared: got req=%b res=%b want 0/0", sawReq, sawRes); end
    enqueue(1, 2'b01, 0, 4'd9, 32'h400, 32'h0);
    waitReq(4, seen);
    checks++;
    if (!seen || dataAddrOut !== 32'h400) begin
      fails++;
      $display("FAIL io_after_clear_req: got seen=%b addr=%h want 1/00000400", seen, dataAddrOut);
    end
    respondLoad(32'h0000007F);
    checks++;
    if (resultValid !== 1'b1 || resultRobId !== 4'd9 || resultValue !== 32'h0000007F) begin
      fails++;
      $display("FAIL io_after_clear_res: got rv=%b rob=%h val=%h want 1/9/0000007f", resultValid, resultRobId, resultValue);
    end
  endtask

  task automatic test_clear();
    bit seen, sawReq, sawRes;
    doReset();
    enqueue(0, 2'b11, 0, 4'd1, 32'h500, 32'hCAFEF00D);
    enqueue(1, 2'b11, 0, 4'd2, 32'h600, 32'h0);
    enqueue(1, 2'b11, 0, 4'd3, 32'h604, 32'h0);
    commitId(4'd1);
    waitReq(4, seen);
    checks++;
    if (!seen || readWriteOut !== 1'b0 || dataAddrOut !== 32'h500 || dataOut !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL clr_store_req: got seen=%b rw=%b addr=%h data=%h want 1/0/00000500/cafef00d", seen, readWriteOut, dataAddrOut, dataOut);
    end
    tick();
    clearIn = 1;
    tick();
    clearIn = 0;
    quiet(4, sawReq, sawRes);
    checks++;
    if (sawReq || sawRes) begin fails++; $display("FAIL clr_during_store: got req=%b res=%b want 0/0", sawReq, sawRes); end
    dataWriteSuc = 1;
    tick();
    dataWriteSuc = 0;
    quiet(8, sawReq, sawRes);
    checks++;
    if (sawReq || sawRes) begin fails++; $display("FAIL clr_loads_dropped: got req=%b res=%b want 0/0", sawReq, sawRes); end
    enqueue(1, 2'b11, 0, 4'd4, 32'h700, 32'h0);
    waitReq(4, seen);
    tick();
    clearIn = 1; dataInValid = 1; dataIn = 32'h12345678;
    tick();
    clearIn = 0; dataInValid = 0;
    checks++;
    if (resultValid !== 1'b0) begin fails++; $display("FAIL clr_wait_load_result: got rv=%b want 0", resultValid); end
    quiet(5, sawReq, sawRes);
    checks++;
    if (sawReq || sawRes) begin fails++; $display("FAIL clr_wait_load_quiet: got req=%b res=%b want 0/0", sawReq, sawRes); end
    enqueue(1, 2'b11, 0, 4'd5, 32'h704, 32'h0);
    waitReq(4, seen);
    checks++;
    if (!seen || dataAddrOut !== 32'h704) begin
      fails++;
      $display("FAIL clr_recover_req: got seen=%b addr=%h want 1/00000704", seen, dataAddrOut);
    end
    respondLoad(32'h0BADF00D);
    checks++;
    if (resultValid !== 1'b1 || resultRobId !== 4'd5 || resultValue !== 32'h0BADF00D) begin
      fails++;
      $display("FAIL clr_recover_res: got rv=%b rob=%h val=%h want 1/5/0badf00d", resultValid, resultRobId, resultValue);
    end
  endtask

  task automatic test_async_reset();
    bit seen, sawReq, sawRes;
    doReset();
    enqueue(1, 2'b11, 0, 4'd6, 32'h800, 32'h0);
    waitReq(4, seen);
    respondLoad(32'hA5A5A5A5);
    enqueue(1, 2'b11, 0, 4'd7, 32'h804, 32'h0);
    waitReq(4, seen);
    tick();
    #2;
    resetIn = 0;
    #1;
    checks++;
    if (accessType !== 2'b00 || readWriteOut !== 1'b1 || dataAddrOut !== 32'h0 || dataOut !== 32'h0) begin
      fails++;
      $display("FAIL async_reset_request: got at=%b rw=%b addr=%h data=%h want 00/1/0/0", accessType, readWriteOut, dataAddrOut, dataOut);
    end
    checks++;
    if (resultValid !== 1'b0 || resultRobId !== 4'h0 || resultValue !== 32'h0 || issueReady !== 1'b1) begin
      fails++;
      $display("FAIL async_reset_result: got rv=%b rob=%h val=%h ready=%b want 0/0/0/1", resultValid, resultRobId, resultValue, issueReady);
    end
    tick();
    resetIn = 1;
    dataInValid = 1; dataIn = 32'h11223344;
    tick();
    dataInValid = 0;
    quiet(4, sawReq, sawRes);
    checks++;
    if (resultValid !== 1'b0 || sawReq || sawRes) begin
      fails++;
      $display("FAIL async_reset_stale_data: got rv=%b req=%b res=%b want 0/0/0", resultValid, sawReq, sawRes);
    end
  endtask

  task automatic test_random();
    entry_t mq[$];
    entry_t e, ne;
    bit outstanding = 0, justSeen = 0, expectRes = 0, popNow, enqNow, io;
    int delay = 0, commitIdx;
    logic [3:0] expRob = 0, nextRob = 0;
    logic [31:0] expVal = 0, raw, a;
    doReset();
    for (int cyc = 0; cyc < 1600; cyc++) begin
      checks++;
      if (expectRes) begin
        if (resultValid !== 1'b1 || resultRobId !== expRob || resultValue !== expVal) begin
          fails++;
          $display("FAIL rnd_result c%0d: got rv=%b rob=%h val=%h want 1/%h/%h", cyc, resultValid, resultRobId, resultValue, expRob, expVal);
        end
        expectRes = 0;
      end else if (resultValid !== 1'b0) begin
        fails++;
        $display("FAIL rnd_spurious_result c%0d: got rv=1 want 0", cyc);
      end
      if (accessType !== 2'b00) begin
        checks++;
        if (outstanding || mq.size() == 0) begin
          fails++;
          $display("FAIL rnd_unexpected_req c%0d: got at=%b want 00 (outstanding=%0d size=%0d)", cyc, accessType, outstanding, mq.size());
        end else begin
          e = mq[0];
          if (!(e.committed || (e.isLoad && e.addr[17:16] != 2'b11)) || accessType !== e.at ||
              readWriteOut !== e.isLoad || dataAddrOut !== e.addr || (!e.isLoad && dataOut !== e.data)) begin
            fails++;
            $display("FAIL rnd_req c%0d: got at=%b rw=%b addr=%h data=%h want %b/%b/%h/%h committed=%0d",
                     cyc, accessType, readWriteOut, dataAddrOut, dataOut, e.at, e.isLoad, e.addr, e.data, e.committed);
          end
          outstanding = 1;
          justSeen    = 1;
          delay       = $urandom_range(1, 3);
        end
      end
      checks++;
      if (issueReady !== (mq.size() != 8)) begin
        fails++;
        $display("FAIL rnd_ready c%0d: got %b want %b", cyc, issueReady, mq.size() != 8);
      end

      clearInputs();
      popNow    = 0;
      enqNow    = 0;
      commitIdx = -1;
      if (outstanding && !justSeen) begin
        delay--;
        if (delay == 0) begin
          popNow      = 1;
          outstanding = 0;
          if (mq[0].isLoad) begin
            raw = $urandom;
            if (mq[0].at == 2'b01) raw = raw & 32'hFF;
            else if (mq[0].at == 2'b10) raw = raw & 32'hFFFF;
            dataInValid = 1; dataIn = raw;
            expectRes = 1;
            expRob    = mq[0].rob;
            expVal    = extendRef(mq[0].at, mq[0].sgn, raw);
          end else begin
            dataWriteSuc = 1;
          end
        end
      end
      justSeen = 0;
      if (cyc < 1300 && $urandom_range(0, 2) != 0) begin
        io = ($urandom_range(0, 3) == 0);
        a = $urandom;
        a[31:18] = '0;
        a[17:16] = io ? 2'b11 : 2'($urandom_range(0, 2));
        ne.at = 2'($urandom_range(1, 3));
        if (ne.at == 2'b10) a[0] = 1'b0;
        if (ne.at == 2'b11) a[1:0] = 2'b00;
        ne.isLoad = ($urandom_range(0, 2) != 0);
        ne.sgn = 1'($urandom_range(0, 1));
        ne.rob = nextRob;
        ne.addr = a;
        ne.data = $urandom;
        ne.committed = 0;
        issueValid = 1; issueIsLoad = ne.isLoad; issueAccessType = ne.at; issueSigned = ne.sgn;
        issueRobId = ne.rob; issueAddr = ne.addr; issueData = ne.data;
        enqNow = (mq.size() < 8);
      end
      for (int k = 0; k < mq.size(); k++) begin
        if (!mq[k].committed) begin
          commitIdx = k;
          break;
        end
      end
      if (commitIdx >= 0 && $urandom_range(0, 2) == 0) begin
        commitValid = 1; commitRobId = mq[commitIdx].rob;
      end else begin
        commitIdx = -1;
      end
      tick();
      if (commitIdx >= 0) mq[commitIdx].committed = 1;
      if (popNow) void'(mq.pop_front());
      if (enqNow) begin
        mq.push_back(ne);
        nextRob = nextRob + 1'b1;
      end
    end
    clearInputs();
    checks++;
    if (mq.size() != 0 || outstanding) begin
      fails++;
      $display("FAIL rnd_drain: got %0d entries left outstanding=%0d want 0/0", mq.size(), outstanding);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store();
    test_full_wrap();
    test_io_load();
    test_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/load_store_buffer.md
# load_store_buffer

In-order circular queue of memory operations between the issue stage and the `Cache` data port (`accessType`/`dataAddrIn`/`dataIn` in, `dataOutValid`/`dataOut`/`dataWriteSuc` out).
- Accepts loads and stores with resolved addresses and data.
- Sends each head entry to the cache as a single request and waits for its response.
- Broadcasts load results, extended to 32 bits, tagged with the ROB id.
- Holds stores (and I/O loads) until the reorder buffer commits them; discards speculative entries on branch misprediction.

## Interface
- `LSB_WIDTH`, 3: log2 of entry count (8 entries).
- `ROB_WIDTH`, 4: ROB id width.

- `clkIn` in 1: system clock.
- `resetIn` in 1: reset, asynchronous, active-low.
- `clearIn` in 1: misprediction flush.
- `issueValid` in 1: enqueue request.
- `issueReady` out 1: entry free (count < 2^LSB_WIDTH).
- `issueIsLoad` in 1: 1 = load, 0 = store.
- `issueAccessType` in 2: 01 byte, 10 half, 11 word.
- `issueSigned` in 1: sign-extend load result.
- `issueRobId` in ROB_WIDTH: ROB tag.
- `issueAddr` in 32: naturally aligned address.
- `issueData` in 32: store data (low bytes used).
- `commitValid` in 1: ROB commit strobe.
- `commitRobId` in ROB_WIDTH: committed tag.
- `accessType` out 2: cache request type; 00 = none.
- `readWriteOut` out 1: 1 read, 0 write.
- `dataAddrOut` out 32: request address.
- `dataOut` out 32: store data.
- `dataInValid` in 1: cache load data valid.
- `dataIn` in 32: cache load data, zero-extended by the cache.
- `dataWriteSuc` in 1: cache store complete.
- `resultValid` out 1: load result broadcast.
- `resultRobId` out ROB_WIDTH: result tag.
- `resultValue` out 32: extended load value.

## Operation
- Entry fields:
  - `valid`, `committed`, `isLoad`, `accessType[1:0]`, `signed`, `robId`, `addr[31:0]`, `data[31:0]`.
  - Queue pointers: `head` and `tail` (LSB_WIDTH bits, wrap modulo size), plus `count` (LSB_WIDTH+1 bits).
- Enqueue: on `issueValid && issueReady`, write the entry at `tail` with `committed=0`, then `tail+1` and `count+1`.
  - `issueReady` is combinational `count != 2^LSB_WIDTH`.
  - It is 0 when full, even if a pop happens in the same cycle.
- Commit: on `commitValid`, every valid entry with `robId == commitRobId` sets `committed=1`.
  - The commit applies to an entry being enqueued in the same cycle.
- Head eligible when `valid` and either condition holds:
  - it is a load with `addr[17:16] != 2'b11`, or
  - `committed=1` (all stores, and I/O loads).
- FSM states: IDLE, WAIT_LOAD, WAIT_STORE.
  - IDLE, head eligible: drive the request (`accessType`, `readWriteOut`, `dataAddrOut`, `dataOut`) for exactly one cycle, then return `accessType` to 00. Next state is WAIT_LOAD or WAIT_STORE.
  - WAIT_LOAD, `dataInValid`: register the result, pop head, go to IDLE.
  - WAIT_STORE, `dataWriteSuc`: pop head, go to IDLE.
- Extension rules:
  - byte: sign or zero extend from `dataIn[7]`;
  - half: sign or zero extend from `dataIn[15]`;
  - word: pass `dataIn` through.
- Clear (`clearIn`):
  - Invalidate every uncommitted entry. Committed entries form a contiguous prefix from `head`.
  - Set `tail` = `head` + committed count and `count` = committed count.
  - Any `issueValid` in the same cycle is dropped.
  - WAIT_LOAD: go to IDLE, drop the head entry, suppress the result. The cache abandons the read on `clearIn`, so no stale `dataInValid` follows.
  - WAIT_STORE: continues; a store is always committed.
  - A `dataWriteSuc` in the clear cycle pops normally.
  - A `dataInValid` in the clear cycle produces no `resultValid`.
- Reset (any time):
  - `head`, `tail`, `count` = 0; all `valid` = 0; state IDLE.
  - Any in-flight cache operation is abandoned; the cache shares the reset.

## Timing
- Reset values:
  - `accessType=00`, `readWriteOut=1`, `dataAddrOut=0`, `dataOut=0`;
  - `resultValid=0`, `resultRobId=0`, `resultValue=0`;
  - `issueReady=1`.
- Request: the head becomes eligible at edge E. The request outputs are registered and visible for the one cycle after E.
- Result: `dataInValid` sampled at edge N gives `resultValid=1` for exactly the cycle after N.
  - The head pop happens at the same edge N.
  - The next request is driven at the earliest in the cycle after N+1.
- An enqueue into an empty queue becomes eligible one edge later. Minimum latency to request is 2 cycles after `issueValid`.
- `accessType` is never nonzero while in WAIT_LOAD or WAIT_STORE.

## Test plan
- Load byte at 0x100, signed, cache returns 0x000000F0 -> `resultValid` for 1 cycle, `resultValue=0xFFFFFFF0`. With unsigned -> `0x000000F0`.
- Store word 0xDEADBEEF at 0x200, robId 5:
  - no request until `commitValid` with id 5;
  - then one cycle of `accessType=11`, `readWriteOut=0`, `dataOut=0xDEADBEEF`;
  - the pop follows `dataWriteSuc`.
- Enqueue 8 loads with no cache response -> `issueReady=0` after the 8th. Drain all -> `count=0`. The 9th enqueue wraps `tail` to 1.
- Load to 0x30000 -> no request until committed. Uncommitted load to 0x30004 followed by `clearIn` -> entry dropped, no request.
- Entries: committed store (id1), load (id2) in WAIT_LOAD... reorder so the store is at head in WAIT_STORE, plus two uncommitted loads; assert `clearIn`:
  - `count=1`;
  - the store completes;
  - no `resultValid` for ids 2 or 3.
- Assert `resetIn=0` mid WAIT_LOAD -> all outputs immediately return to reset values, asynchronously and without a clock edge; a later `dataInValid` is ignored.
